// File: rtl/ifu_decd_if.sv
// Instruction-memory fetch bus between ifu_decd (master) and the instruction memory (slave).
interface ifu_decd_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_ack,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_ack,
    output im_rdata
  );
endinterface

// File: rtl/ifu_decd.sv
// Multicycle MIPS32 fetch/decode unit: owns PC and IR, fetches over req/ack,
// decodes into the 7-bit control class and applies the next-PC update.
module ifu_decd #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        clr,
  ifu_decd_if.master  im,
  input  logic        PCWr,
  input  logic [1:0]  nPCOp,
  input  logic        zero,
  output logic [6:0]  decdOp,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t      state, state_nxt;
  logic        load_ir;
  logic        load_pc;
  logic [31:0] npc;
  logic [31:0] br_off;

  function automatic logic [6:0] decode(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] funct;
    op    = w[31:26];
    funct = w[5:0];
    if      (op == 6'h00 && funct == 6'h21) decode = 7'b1000011;
    else if (op == 6'h00 && funct == 6'h23) decode = 7'b1000111;
    else if (op == 6'h0D)                   decode = 7'b0011010;
    else if (op == 6'h23)                   decode = 7'b1000110;
    else if (op == 6'h2B)                   decode = 7'b1010110;
    else if (op == 6'h04)                   decode = 7'b0001000;
    else if (op == 6'h02)                   decode = 7'b0000100;
    else                                    decode = 7'b0000000;
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    state_nxt = state;
    im.im_req = 1'b0;
    ir_valid  = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        im.im_req = 1'b1;
        if (im.im_ack) begin
          load_ir   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        ir_valid = 1'b1;
        if (PCWr) begin
          load_pc   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    npc = pc4;
    unique case (nPCOp)
      2'b01:   npc = zero ? (pc4 + br_off) : pc4;
      2'b10:   npc = {pc4[31:28], ir[25:0], 2'b00};
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc     <= RESET_PC;
      ir     <= '0;
      decdOp <= '0;
    end else begin
      if (load_pc) pc <= npc;
      if (load_ir) begin
        ir     <= im.im_rdata;
        decdOp <= decode(im.im_rdata);
      end
    end
  end

  assign im.im_addr = pc;
  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign rd         = ir[15:11];
  assign imm16      = ir[15:0];

endmodule
